// File: rtl/mem_1cyc_initiator.sv
// Byte-addressed load/store adapter onto a word-wide single-cycle RAM port.
// Misaligned accesses become two beats; read data is merged, aligned and extended.
module mem_1cyc_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_en,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_size,
    output logic [3:0]            mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    sgn_q;
    logic [31:0]             wdata_q;
    logic [31:0]             lo;
    logic [31:0]             hi;

    logic [1:0]              cur_off;
    logic [1:0]              cur_size;
    logic [31:0]             cur_wdata;
    logic [7:0]              cur_m;
    logic [63:0]             cur_w;
    logic                    cur_split;

    function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [1:0] size);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] lane_data(input logic [1:0] off, input logic [31:0] wdata);
        return {32'b0, wdata} << {off, 3'b000};
    endfunction

    function automatic logic is_split(input logic [1:0] off, input logic [1:0] size);
        logic [2:0] nbytes;
        logic [2:0] last;
        case (size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        last = {1'b0, off} + nbytes;
        return last > 3'd4;
    endfunction

    function automatic logic [31:0] assemble(input logic [31:0] hi_w, input logic [31:0] lo_w,
                                             input logic [1:0] off, input logic [1:0] size,
                                             input logic sgn);
        logic [31:0] s;
        s = 32'({hi_w, lo_w} >> {off, 3'b000});
        case (size)
            2'd0:    return sgn ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
            2'd1:    return sgn ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Lane math follows the incoming request while idle (beat0 is launched on the
    // accept edge) and the latched request afterwards (beat1 and the split decision).
    always_comb begin
        cur_off   = addr_q[1:0];
        cur_size  = size_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_off   = req_addr[1:0];
            cur_size  = req_size;
            cur_wdata = req_wdata;
        end
        cur_m     = lane_mask(cur_off, cur_size);
        cur_w     = lane_data(cur_off, cur_wdata);
        cur_split = is_split(cur_off, cur_size);
    end

    assign mem_size = 2'd2;

    // All outputs are registered, so each beat's strobes are set up on the edge
    // that enters the beat state and cleared on the edge that leaves it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            sgn_q      <= 1'b0;
            wdata_q    <= '0;
            lo         <= '0;
            hi         <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wmask  <= 4'h0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        sgn_q     <= req_signed;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_we    <= req_we;
                        mem_re    <= !req_we;
                        mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wmask <= req_we ? cur_m[3:0] : 4'h0;
                        mem_wdata <= cur_w[31:0];
                        state     <= BEAT0;
                    end
                end
                BEAT0: begin
                    lo <= mem_rdata;
                    if (cur_split) begin
                        mem_addr  <= {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
                        mem_wmask <= we_q ? cur_m[7:4] : 4'h0;
                        mem_wdata <= cur_w[63:32];
                        state     <= BEAT1;
                    end else begin
                        hi         <= '0;
                        mem_en     <= 1'b0;
                        mem_re     <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_wmask  <= 4'h0;
                        mem_wdata  <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? 32'b0 : assemble(32'b0, mem_rdata, addr_q[1:0], size_q, sgn_q);
                        state      <= RESP;
                    end
                end
                BEAT1: begin
                    hi         <= mem_rdata;
                    mem_en     <= 1'b0;
                    mem_re     <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_addr   <= '0;
                    mem_wmask  <= 4'h0;
                    mem_wdata  <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= we_q ? 32'b0 : assemble(mem_rdata, lo, addr_q[1:0], size_q, sgn_q);
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
